// File: rtl/interp_serial_pkg.sv
// Shared constants for the serial 2x interpolator family: fixed-point widths,
// default prototype length, coefficient table and FSM state encoding.
package interp_serial_pkg;

   localparam int NTAP_DEF = 12;
   localparam int W_DATA   = 16;
   localparam int W_PROD   = 32;
   localparam int W_ACC    = 33;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MAC0 = 3'd1,
      ST_OUT0 = 3'd2,
      ST_MAC1 = 3'd3,
      ST_OUT1 = 3'd4
   } state_t;

   // Prototype low-pass h[], sfix16_En16; even entries feed phase 0, odd entries phase 1
   localparam logic signed [W_DATA-1:0] H_TABLE [NTAP_DEF] = '{
      -16'sd514,  -16'sd1030,  16'sd1538,  16'sd4098,
      -16'sd3074,  16'sd19458, 16'sd30722, 16'sd19458,
      -16'sd3074,  16'sd4098,  16'sd1538, -16'sd1030
   };

   // Coefficient lookup; indices outside the table read as zero
   function automatic logic signed [W_DATA-1:0] coef(input int idx);
      logic signed [W_DATA-1:0] c;
      if ((idx >= 0) && (idx < NTAP_DEF)) begin
         c = H_TABLE[idx];
      end else begin
         c = 16'sd0;
      end
      return c;
   endfunction

endpackage

// File: rtl/interp_serial_x2_if.sv
// Streaming handshake bundle for the interpolator: sample in, interpolated sample out.
interface interp_serial_x2_if;
   import interp_serial_pkg::*;

   logic [W_DATA-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [W_DATA-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/interp_serial_x2_round_conv.sv
// Convergent (round-half-to-even) reduction of an En31 accumulator to En15,
// keeping the low 16 bits so out-of-range results wrap.
module round_conv_33to16
   import interp_serial_pkg::*;
(
   input  logic [W_ACC-1:0]  acc,
   output logic [W_DATA-1:0] res
);

   logic [W_ACC:0] biased_s;
   logic           unused_bits_s;

   // Add just under half an LSB, plus the kept LSB, so exact ties move only when odd
   always_comb begin
      biased_s      = {acc[W_ACC-1], acc} + {18'd0, 16'h7FFF} + {33'd0, acc[16]};
      res           = biased_s[31:16];
      unused_bits_s = ^{biased_s[W_ACC:32], biased_s[15:0]};
   end

endmodule

// File: rtl/interp_serial_x2.sv
// Serial 2x polyphase interpolator: one shared multiplier and accumulator walk
// the NTAP/2-word delay line once per phase, producing two outputs per input.
module interp_serial_x2
   import interp_serial_pkg::*;
#(
   parameter int NTAP = NTAP_DEF
)
(
   input  logic              clk,
   input  logic              syn_rst,
   input  logic              clk_enable,
   interp_serial_x2_if.slave bus
);

   localparam int NHALF = NTAP / 2;
   localparam int CW    = (NHALF > 1) ? $clog2(NHALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NHALF - 1);

   state_t                   state_r;
   logic [CW-1:0]            cnt_r;
   logic signed [W_ACC-1:0]  acc_r;
   logic signed [W_DATA-1:0] dline_r [NHALF];
   logic [W_DATA-1:0]        out_data_r;
   logic                     out_valid_r;
   logic                     in_ready_r;

   logic                     phase_s;
   logic signed [W_DATA-1:0] tap_s;
   logic signed [W_DATA-1:0] coef_s;
   logic signed [W_PROD-1:0] prod_s;
   logic signed [W_ACC-1:0]  acc_next_s;
   logic [W_DATA-1:0]        rnd_s;
   logic                     in_hs_s;
   logic                     out_hs_s;

   // One MAC step: pick tap/coefficient for this count and phase; first tap loads, later taps add
   always_comb begin
      phase_s  = (state_r == ST_MAC1);
      tap_s    = dline_r[cnt_r];
      coef_s   = coef((2 * int'(cnt_r)) + int'(phase_s));
      prod_s   = W_PROD'(tap_s) * W_PROD'(coef_s);
      if (cnt_r == '0) begin
         acc_next_s = {prod_s[W_PROD-1], prod_s};
      end else begin
         acc_next_s = acc_r + {prod_s[W_PROD-1], prod_s};
      end
      in_hs_s  = bus.in_valid & in_ready_r & clk_enable;
      out_hs_s = bus.out_ready & out_valid_r & clk_enable;
   end

   round_conv_33to16 u_round (
      .acc (acc_next_s),
      .res (rnd_s)
   );

   // Sequencer, delay line, accumulator and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!syn_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         acc_r       <= '0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         for (int i = 0; i < NHALF; i++) begin
            dline_r[i] <= '0;
         end
      end else if (clk_enable) begin
         case (state_r)
            ST_IDLE: begin
               if (in_hs_s) begin
                  for (int i = NHALF - 1; i > 0; i--) begin
                     dline_r[i] <= dline_r[i-1];
                  end
                  dline_r[0] <= $signed(bus.in_data);
                  in_ready_r <= 1'b0;
                  cnt_r      <= '0;
                  state_r    <= ST_MAC0;
               end
            end
            ST_MAC0, ST_MAC1: begin
               acc_r <= acc_next_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_r       <= '0;
                  out_data_r  <= rnd_s;
                  out_valid_r <= 1'b1;
                  state_r     <= (state_r == ST_MAC0) ? ST_OUT0 : ST_OUT1;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_OUT0: begin
               if (out_hs_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_MAC1;
               end
            end
            ST_OUT1: begin
               if (out_hs_s) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= '0;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;

endmodule
